mv_pattern_box: RTL and testbench
=================================

Name: mv_pattern_box

Overview:
- Downstream consumer of the x/y timing stage. Takes delayed video timing, pixel data and 1-based active-pixel coordinates, and overlays test patterns for HDMI bring-up: a coordinate grid and/or a solid box that bounces around the frame.
- Result drives the HDMI encoder path.
- Box position and pattern mode update once per frame, at the vs rising edge, so the picture never tears.

Parameters:
- BITS_PER_CHANNEL, 8, bits per colour channel
- CHANNELS_PER_PIXEL, 3, channels per pixel; DW = BITS_PER_CHANNEL*CHANNELS_PER_PIXEL
- H_ACTIVE, 1920, active pixels per line
- V_ACTIVE, 1080, active lines per frame
- BOX_SIZE, 64, box edge in pixels; must satisfy 1 <= BOX_SIZE <= min(H_ACTIVE, V_ACTIVE)
- GRID_SHIFT, 6, grid pitch = 2^GRID_SHIFT pixels

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- i_hs  in  1  hsync, aligned with x/y
- i_vs  in  1  vsync, active high
- i_de  in  1  data enable
- i_data  in  DW  pixel data
- x  in  12  column; 1 on the first active pixel of a line
- y  in  12  row; 1 on the first active line of a frame
- mode  in  2  0 passthrough, 1 grid, 2 box, 3 grid+box
- step  in  4  box motion, pixels per frame on each axis; 0 freezes the box
- box_color  in  DW  fill colour of the box
- o_hs  out  1  delayed hsync
- o_vs  out  1  delayed vsync
- o_de  out  1  delayed data enable
- o_data  out  DW  overlaid pixel data
- frame_tick  out  1  one-cycle pulse on each frame update

Behaviour:
- Reset: all outputs 0; box position bx=1, by=1; direction right/down; latched mode = 0; latched step = 0; vs delay register = 0.
- Latency: o_hs, o_vs, o_de and o_data lag their inputs by exactly 2 clocks.
- Stage 1 (registered):
  - in_box = (bx <= x <= bx+BOX_SIZE-1) and (by <= y <= by+BOX_SIZE-1).
  - on_grid = ((x-1) mod 2^GRID_SHIFT == 0) or ((y-1) mod 2^GRID_SHIFT == 0) or x==H_ACTIVE or y==V_ACTIVE.
  - Data and sync signals are delayed alongside.
- Stage 2 output mux, highest priority first:
  - de low: data passed through unchanged.
  - in_box and latched mode bit1 set: box_color.
  - on_grid and latched mode bit0 set: all-ones (white).
  - Otherwise: the delayed input data.
- Frame update:
  - vs_edge = i_vs & ~vs_d (vs_d registered, reset 0). If i_vs is high when reset deasserts, the first clock counts as an edge.
  - On vs_edge, the next clock: latch mode and step, move the box, and pulse frame_tick for 1 cycle.
  - Mode/step changes mid-frame take effect only at the next frame.
- Horizontal motion. All arithmetic is 13-bit unsigned, so nothing wraps.
  - Moving right: if bx+BOX_SIZE-1+step > H_ACTIVE, then bx = H_ACTIVE-BOX_SIZE+1 and direction becomes left; else bx += step.
  - Moving left: if bx <= step, then bx = 1 and direction becomes right; else bx -= step.
  - Landing exactly on the edge does not flip direction; the flip happens on the following frame.
- Vertical motion: identical rules using by, V_ACTIVE and the up/down direction.
- Box motion uses the newly latched step, not the previous one.
- Reset mid-frame: everything returns to reset values immediately. Output stays 0 until the pipeline refills (2 clocks).

Decomposition:
- Shared package: mode encodings (MODE_PASS=0, MODE_GRID=1, MODE_BOX=2, MODE_BOTH=3), white constant, coordinate width 12.
- One natural sub-module, mv_box_motion:
  - contains per-frame position/direction registers and bounce arithmetic;
  - inputs: vs_edge, step;
  - outputs: bx, by, frame_tick.
- Top level keeps the 2-stage pixel pipeline and the mux.

Test Plan:
All scenarios use H_ACTIVE=128, V_ACTIVE=96, BOX_SIZE=16, GRID_SHIFT=4, with a simple timing model driving x/y.
1. Passthrough: mode=0, i_data=ramp -> o_data equals i_data delayed 2 clocks; o_hs/o_vs/o_de equal inputs delayed 2 clocks.
2. Grid: mode=1, i_data=0 -> o_data=all-ones at x=1,17,33,…,128 and on rows y=1,17,…,96; zero elsewhere; zero whenever de is low.
3. Box after reset: mode=2, step=0, box_color=0xFF0000 -> 0xFF0000 exactly for x,y in 1..16 in every frame; one frame_tick per frame.
4. Bounce: step=8, mode=3 -> bx sequence 1,9,…,105,113,113,105; by sequence 1,9,…,73,81,81,73; box overrides grid where they overlap.
5. Mid-frame change: set mode 0→2 at y=40 -> current frame stays passthrough; box appears from the next frame; the step latch timing matches.
6. Reset mid-line: drop rst_n at x=50 -> all outputs 0 in the same cycle; after release bx=by=1; o_de resumes 2 clocks after i_de.

Source files
------------

// File: rtl/mv_pattern_box_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mv_pattern_box_pkg
// Description : Shared definitions for the HDMI bring-up pattern overlay.
//               Holds the overlay mode encodings, the white pixel constant,
//               the coordinate width and the per-axis bounce helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mv_pattern_box_pkg;

    // Coordinate width of the incoming x/y counters.
    localparam int c_COORD_W = 12;
    // One extra bit so that position + size + step can never wrap.
    localparam int c_POS_W   = c_COORD_W + 1;

    // Overlay mode encodings: bit0 enables the grid, bit1 enables the box.
    localparam logic [1:0] c_MODE_PASS = 2'd0;
    localparam logic [1:0] c_MODE_GRID = 2'd1;
    localparam logic [1:0] c_MODE_BOX  = 2'd2;
    localparam logic [1:0] c_MODE_BOTH = 2'd3;

    // All-ones pixel; consumers slice the low DW bits (DW up to 64).
    localparam logic [63:0] c_WHITE = '1;

    // Position and travel direction of the box along one axis.
    typedef struct packed {
        logic [c_COORD_W-1:0] pos;
        logic                 fwd;   // 1 = right/down, 0 = left/up
    } axis_t;

    // One frame of bounce motion along one axis. A box that would overshoot
    // the far edge is clamped there and turned around; landing exactly on an
    // edge keeps the direction, so the turn happens on the following frame.
    function automatic axis_t bounce(
        input logic [c_COORD_W-1:0] pos,
        input logic                 fwd,
        input logic [3:0]           step,
        input logic [c_POS_W-1:0]   limit,
        input logic [c_POS_W-1:0]   size
    );
        axis_t              r;
        logic [c_POS_W-1:0] p;
        logic [c_POS_W-1:0] s;
        p     = {1'b0, pos};
        s     = {{(c_POS_W-4){1'b0}}, step};
        r.pos = pos;
        r.fwd = fwd;
        if (fwd) begin
            if (p + size - c_POS_W'(1) + s > limit) begin
                r.pos = c_COORD_W'(limit - size + c_POS_W'(1));
                r.fwd = 1'b0;
            end else begin
                r.pos = c_COORD_W'(p + s);
            end
        end else begin
            if (p <= s) begin
                r.pos = c_COORD_W'(1);
                r.fwd = 1'b1;
            end else begin
                r.pos = c_COORD_W'(p - s);
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mv_pattern_box_motion.sv
`default_nettype none
// ============================================================================
// Module      : mv_box_motion
// Description : Per-frame position and direction of the bouncing box.
//               Moves the box once per frame on vs_edge using the step value
//               presented with that edge, and pulses frame_tick.
// Ports       : clk, rst_n      - pixel clock, async active-low reset
//               vs_edge         - one-cycle frame-start strobe
//               step[3:0]       - pixels per frame on each axis (0 = frozen)
//               bx, by [11:0]   - top-left corner of the box, 1-based
//               frame_tick      - one-cycle pulse on each frame update
// Revision    : 1.0 - initial release
// ============================================================================
module mv_box_motion
    import mv_pattern_box_pkg::*;
#(
    parameter int H_ACTIVE = 1920,
    parameter int V_ACTIVE = 1080,
    parameter int BOX_SIZE = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 vs_edge,
    input  logic [3:0]           step,
    output logic [c_COORD_W-1:0] bx,
    output logic [c_COORD_W-1:0] by,
    output logic                 frame_tick
);

    localparam logic [c_POS_W-1:0] c_H_LIM = c_POS_W'(H_ACTIVE);
    localparam logic [c_POS_W-1:0] c_V_LIM = c_POS_W'(V_ACTIVE);
    localparam logic [c_POS_W-1:0] c_BOX   = c_POS_W'(BOX_SIZE);

    logic  r_right;
    logic  r_down;
    axis_t w_h_next;
    axis_t w_v_next;

    // The step seen on the edge is the value latched for this frame, so it is
    // consumed directly rather than through a separate holding register.
    assign w_h_next = bounce(bx, r_right, step, c_H_LIM, c_BOX);
    assign w_v_next = bounce(by, r_down,  step, c_V_LIM, c_BOX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bx         <= c_COORD_W'(1);
            by         <= c_COORD_W'(1);
            r_right    <= 1'b1;
            r_down     <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= vs_edge;
            if (vs_edge) begin
                bx      <= w_h_next.pos;
                r_right <= w_h_next.fwd;
                by      <= w_v_next.pos;
                r_down  <= w_v_next.fwd;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mv_pattern_box.sv
`default_nettype none
// ============================================================================
// Module      : mv_pattern_box
// Description : Test-pattern overlay for HDMI bring-up. Draws a coordinate
//               grid and/or a bouncing solid box over the incoming video.
//               Two-stage pipeline: stage 1 classifies the pixel, stage 2
//               selects the output. Mode and box position change only at the
//               vs rising edge so a frame never tears.
// Ports       : clk, rst_n             - pixel clock, async active-low reset
//               i_hs, i_vs, i_de       - input timing (vs active high)
//               i_data[DW-1:0]         - input pixel
//               x, y [11:0]            - 1-based active pixel coordinates
//               mode[1:0]              - 0 pass, 1 grid, 2 box, 3 grid+box
//               step[3:0]              - box motion per frame
//               box_color[DW-1:0]      - box fill colour
//               o_hs, o_vs, o_de       - timing delayed by 2 clocks
//               o_data[DW-1:0]         - overlaid pixel, delayed by 2 clocks
//               frame_tick             - one-cycle pulse per frame update
// Revision    : 1.0 - initial release
// ============================================================================
module mv_pattern_box
    import mv_pattern_box_pkg::*;
#(
    parameter int BITS_PER_CHANNEL   = 8,
    parameter int CHANNELS_PER_PIXEL = 3,
    parameter int H_ACTIVE           = 1920,
    parameter int V_ACTIVE           = 1080,
    parameter int BOX_SIZE           = 64,
    parameter int GRID_SHIFT         = 6
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         i_hs,
    input  logic                                         i_vs,
    input  logic                                         i_de,
    input  logic [BITS_PER_CHANNEL*CHANNELS_PER_PIXEL-1:0] i_data,
    input  logic [c_COORD_W-1:0]                         x,
    input  logic [c_COORD_W-1:0]                         y,
    input  logic [1:0]                                   mode,
    input  logic [3:0]                                   step,
    input  logic [BITS_PER_CHANNEL*CHANNELS_PER_PIXEL-1:0] box_color,
    output logic                                         o_hs,
    output logic                                         o_vs,
    output logic                                         o_de,
    output logic [BITS_PER_CHANNEL*CHANNELS_PER_PIXEL-1:0] o_data,
    output logic                                         frame_tick
);

    localparam int DW = BITS_PER_CHANNEL * CHANNELS_PER_PIXEL;

    localparam logic [c_POS_W-1:0]   c_BOX_M1    = c_POS_W'(BOX_SIZE - 1);
    localparam logic [c_COORD_W-1:0] c_GRID_MASK = c_COORD_W'((1 << GRID_SHIFT) - 1);
    localparam logic [c_COORD_W-1:0] c_H_LAST    = c_COORD_W'(H_ACTIVE);
    localparam logic [c_COORD_W-1:0] c_V_LAST    = c_COORD_W'(V_ACTIVE);

    // ------------------------------------------------------------------
    // Frame-start detection and per-frame latches
    // ------------------------------------------------------------------
    logic       r_vs_d;
    logic       w_vs_edge;
    logic [1:0] r_mode;

    // r_vs_d resets low, so vs held high through reset release still
    // registers as a frame start on the first clock.
    assign w_vs_edge = i_vs & ~r_vs_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_d <= 1'b0;
            r_mode <= c_MODE_PASS;
        end else begin
            r_vs_d <= i_vs;
            if (w_vs_edge) begin
                r_mode <= mode;
            end
        end
    end

    logic [c_COORD_W-1:0] w_bx;
    logic [c_COORD_W-1:0] w_by;

    mv_box_motion #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .BOX_SIZE (BOX_SIZE)
    ) u_motion (
        .clk        (clk),
        .rst_n      (rst_n),
        .vs_edge    (w_vs_edge),
        .step       (step),
        .bx         (w_bx),
        .by         (w_by),
        .frame_tick (frame_tick)
    );

    // ------------------------------------------------------------------
    // Stage 1: classify the pixel
    // ------------------------------------------------------------------
    logic [c_POS_W-1:0]   w_x13;
    logic [c_POS_W-1:0]   w_y13;
    logic [c_POS_W-1:0]   w_bx13;
    logic [c_POS_W-1:0]   w_by13;
    logic [c_COORD_W-1:0] w_xm1;
    logic [c_COORD_W-1:0] w_ym1;
    logic                 w_in_box;
    logic                 w_on_grid;

    assign w_x13  = {1'b0, x};
    assign w_y13  = {1'b0, y};
    assign w_bx13 = {1'b0, w_bx};
    assign w_by13 = {1'b0, w_by};

    assign w_in_box = (w_x13 >= w_bx13) && (w_x13 <= w_bx13 + c_BOX_M1) &&
                      (w_y13 >= w_by13) && (w_y13 <= w_by13 + c_BOX_M1);

    // Grid lines fall on 1-based coordinates 1, 1+pitch, ... plus the last
    // column and row so the frame border is always closed.
    assign w_xm1     = x - c_COORD_W'(1);
    assign w_ym1     = y - c_COORD_W'(1);
    assign w_on_grid = ((w_xm1 & c_GRID_MASK) == '0) ||
                       ((w_ym1 & c_GRID_MASK) == '0) ||
                       (x == c_H_LAST) || (y == c_V_LAST);

    logic          r1_hs;
    logic          r1_vs;
    logic          r1_de;
    logic [DW-1:0] r1_data;
    logic          r1_in_box;
    logic          r1_on_grid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_hs      <= 1'b0;
            r1_vs      <= 1'b0;
            r1_de      <= 1'b0;
            r1_data    <= '0;
            r1_in_box  <= 1'b0;
            r1_on_grid <= 1'b0;
        end else begin
            r1_hs      <= i_hs;
            r1_vs      <= i_vs;
            r1_de      <= i_de;
            r1_data    <= i_data;
            r1_in_box  <= w_in_box;
            r1_on_grid <= w_on_grid;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: output select (blanking passes through untouched)
    // ------------------------------------------------------------------
    logic          w_box_en;
    logic          w_grid_en;
    logic [DW-1:0] w_pix;

    assign w_box_en  = (r_mode & c_MODE_BOX)  != c_MODE_PASS;
    assign w_grid_en = (r_mode & c_MODE_GRID) != c_MODE_PASS;

    always_comb begin
        w_pix = r1_data;
        if (!r1_de) begin
            w_pix = r1_data;
        end else if (r1_in_box && w_box_en) begin
            w_pix = box_color;
        end else if (r1_on_grid && w_grid_en) begin
            w_pix = c_WHITE[DW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_hs   <= 1'b0;
            o_vs   <= 1'b0;
            o_de   <= 1'b0;
            o_data <= '0;
        end else begin
            o_hs   <= r1_hs;
            o_vs   <= r1_vs;
            o_de   <= r1_de;
            o_data <= w_pix;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mv_pattern_box.sv
`default_nettype none
// ============================================================================
// Module      : tb_mv_pattern_box
// Description : Directed self-checking bench for mv_pattern_box using a
//               128x96 frame, 16-pixel box and 16-pixel grid pitch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mv_pattern_box;

    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_hs = 1'b0;
    logic          i_vs = 1'b0;
    logic          i_de = 1'b0;
    logic [DW-1:0] i_data = '0;
    logic [11:0]   x = '0;
    logic [11:0]   y = '0;
    logic [1:0]    mode = '0;
    logic [3:0]    step = '0;
    logic [DW-1:0] box_color = 24'hFF0000;
    logic          o_hs;
    logic          o_vs;
    logic          o_de;
    logic [DW-1:0] o_data;
    logic          frame_tick;

    int checks   = 0;
    int failures = 0;

    mv_pattern_box #(
        .BITS_PER_CHANNEL   (8),
        .CHANNELS_PER_PIXEL (3),
        .H_ACTIVE           (128),
        .V_ACTIVE           (96),
        .BOX_SIZE           (16),
        .GRID_SHIFT         (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_hs       (i_hs),
        .i_vs       (i_vs),
        .i_de       (i_de),
        .i_data     (i_data),
        .x          (x),
        .y          (y),
        .mode       (mode),
        .step       (step),
        .box_color  (box_color),
        .o_hs       (o_hs),
        .o_vs       (o_vs),
        .o_de       (o_de),
        .o_data     (o_data),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic grid_at(input int px, input int py);
        return ((px - 1) % 16 == 0) || ((py - 1) % 16 == 0) || (px == 128) || (py == 96);
    endfunction

    // Starts and ends on a falling edge: one pixel in, output read 2 clocks later.
    task automatic probe(input string tag, input int px, input int py,
                         input logic de, input logic [DW-1:0] d, input logic [DW-1:0] exp);
        x      = 12'(px);
        y      = 12'(py);
        i_de   = de;
        i_data = d;
        @(negedge clk);
        i_de   = 1'b0;
        i_data = '0;
        x      = '0;
        y      = '0;
        @(negedge clk);
        check(tag, 32'(o_data), 32'(exp));
    endtask

    // Frame boundary: one vs pulse, tick expected for exactly one cycle.
    task automatic frame(input string tag);
        i_vs = 1'b1;
        @(negedge clk);
        check({tag, "_tick"}, 32'(frame_tick), 32'd1);
        i_vs = 1'b0;
        @(negedge clk);
        check({tag, "_tick_clr"}, 32'(frame_tick), 32'd0);
    endtask

    logic          hs_h [12];
    logic          vs_h [12];
    logic          de_h [12];
    logic [DW-1:0] d_h  [12];

    int bx_exp [16] = '{9, 17, 25, 33, 41, 49, 57, 65, 73, 81, 89, 97, 105, 113, 113, 105};
    int by_exp [16] = '{9, 17, 25, 33, 41, 49, 57, 65, 73, 81, 81, 73, 65, 57, 49, 41};

    initial begin
        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("rst_hs", 32'(o_hs), 32'd0);
        check("rst_vs", 32'(o_vs), 32'd0);
        check("rst_de", 32'(o_de), 32'd0);
        check("rst_data", 32'(o_data), 32'd0);
        check("rst_tick", 32'(frame_tick), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---------------- 1: passthrough, 2-clock latency ----------------
        for (int i = 0; i < 12; i++) begin
            hs_h[i] = i[0];
            vs_h[i] = (i >= 4 && i < 8);
            de_h[i] = (i % 3 != 0);
            d_h[i]  = 24'(32'h010203 * (i + 1));
            i_hs = hs_h[i]; i_vs = vs_h[i]; i_de = de_h[i]; i_data = d_h[i];
            x = 12'(i + 1); y = 12'd3;
            @(negedge clk);
            if (i > 0) begin
                check("pass_hs", 32'(o_hs), 32'(hs_h[i-1]));
                check("pass_vs", 32'(o_vs), 32'(vs_h[i-1]));
                check("pass_de", 32'(o_de), 32'(de_h[i-1]));
                check("pass_data", 32'(o_data), 32'(d_h[i-1]));
            end
        end
        i_hs = 1'b0; i_vs = 1'b0; i_de = 1'b0; i_data = '0; x = '0; y = '0;
        @(negedge clk);
        check("pass_data_last", 32'(o_data), 32'(d_h[11]));
        check("pass_de_last", 32'(o_de), 32'(de_h[11]));

        // ---------------- 2: grid ----------------
        mode = 2'd1;
        frame("grid_frame");
        probe("grid_x1",    1,  5, 1'b1, 24'h0, 24'hFFFFFF);
        probe("grid_x17",  17,  5, 1'b1, 24'h0, 24'hFFFFFF);
        probe("grid_x33",  33,  5, 1'b1, 24'h0, 24'hFFFFFF);
        probe("grid_x128", 128, 5, 1'b1, 24'h0, 24'hFFFFFF);
        probe("grid_x2",    2,  5, 1'b1, 24'h0, 24'h000000);
        probe("grid_x16",  16,  5, 1'b1, 24'h0, 24'h000000);
        probe("grid_x127", 127, 5, 1'b1, 24'h0, 24'h000000);
        probe("grid_y17",   5, 17, 1'b1, 24'h0, 24'hFFFFFF);
        probe("grid_y96",   5, 96, 1'b1, 24'h0, 24'hFFFFFF);
        probe("grid_y95",   5, 95, 1'b1, 24'h0, 24'h000000);
        probe("grid_de0",   1,  1, 1'b0, 24'h123456, 24'h123456);
        probe("grid_box_off", 1, 2, 1'b1, 24'h0, 24'hFFFFFF);

        // ---------------- 3: frozen box after reset ----------------
        mode = 2'd2; step = 4'd0;
        frame("box_frame1");
        probe("box_1_1",   1,  1, 1'b1, 24'h00AA00, 24'hFF0000);
        probe("box_16_16", 16, 16, 1'b1, 24'h00AA00, 24'hFF0000);
        probe("box_16_1",  16,  1, 1'b1, 24'h00AA00, 24'hFF0000);
        probe("box_17_1",  17,  1, 1'b1, 24'h00AA00, 24'h00AA00);
        probe("box_1_17",   1, 17, 1'b1, 24'h00AA00, 24'h00AA00);
        probe("box_nogrid", 33, 5, 1'b1, 24'h00AA00, 24'h00AA00);
        frame("box_frame2");
        probe("box_frozen", 1, 1, 1'b1, 24'h00AA00, 24'hFF0000);
        probe("box_frozen_out", 17, 17, 1'b1, 24'h00AA00, 24'h00AA00);

        // ---------------- 4: bounce with grid ----------------
        mode = 2'd3; step = 4'd8;
        for (int k = 0; k < 16; k++) begin
            frame("bounce_frame");
            probe("bounce_tl", bx_exp[k], by_exp[k], 1'b1, 24'h0, 24'hFF0000);
            probe("bounce_br", bx_exp[k] + 15, by_exp[k] + 15, 1'b1, 24'h0, 24'hFF0000);
            if (bx_exp[k] > 1)
                probe("bounce_left", bx_exp[k] - 1, by_exp[k], 1'b1, 24'h0,
                      grid_at(bx_exp[k] - 1, by_exp[k]) ? 24'hFFFFFF : 24'h0);
            if (bx_exp[k] + 16 <= 128)
                probe("bounce_right", bx_exp[k] + 16, by_exp[k], 1'b1, 24'h0,
                      grid_at(bx_exp[k] + 16, by_exp[k]) ? 24'hFFFFFF : 24'h0);
            if (by_exp[k] + 16 <= 96)
                probe("bounce_below", bx_exp[k], by_exp[k] + 16, 1'b1, 24'h0,
                      grid_at(bx_exp[k], by_exp[k] + 16) ? 24'hFFFFFF : 24'h0);
        end

        // ---------------- 5: mid-frame mode/step change ----------------
        // Box now at (105,41) moving left/up; a zero step keeps it there.
        mode = 2'd0; step = 4'd0;
        frame("mid_frame0");
        probe("mid_pass_before", 105, 41, 1'b1, 24'h123456, 24'h123456);
        mode = 2'd2; step = 4'd4;
        probe("mid_pass_y40", 105, 40, 1'b1, 24'h123456, 24'h123456);
        probe("mid_pass_still", 105, 41, 1'b1, 24'h123456, 24'h123456);
        frame("mid_frame1");
        probe("mid_box_tl",  101, 37, 1'b1, 24'h123456, 24'hFF0000);
        probe("mid_box_br",  116, 52, 1'b1, 24'h123456, 24'hFF0000);
        probe("mid_box_l",   100, 37, 1'b1, 24'h123456, 24'h123456);
        probe("mid_box_u",   101, 36, 1'b1, 24'h123456, 24'h123456);
        probe("mid_box_r",   117, 37, 1'b1, 24'h123456, 24'h123456);

        // ---------------- 6: reset mid-line ----------------
        x = 12'd50; y = 12'd10; i_de = 1'b1; i_hs = 1'b1; i_data = 24'h0F0F0F;
        @(negedge clk);
        @(negedge clk);
        check("prerst_de", 32'(o_de), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_de", 32'(o_de), 32'd0);
        check("rst_mid_hs", 32'(o_hs), 32'd0);
        check("rst_mid_data", 32'(o_data), 32'd0);
        check("rst_mid_tick", 32'(frame_tick), 32'd0);
        @(negedge clk);
        // Release with vs already high: first clock must count as a frame edge.
        x = 12'd1; y = 12'd1; i_vs = 1'b1; mode = 2'd2; step = 4'd0;
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_tick", 32'(frame_tick), 32'd1);
        check("rel_de_gap", 32'(o_de), 32'd0);
        @(negedge clk);
        check("rel_de", 32'(o_de), 32'd1);
        check("rel_hs", 32'(o_hs), 32'd1);
        check("rel_box_home", 32'(o_data), 32'hFF0000);
        check("rel_tick_clr", 32'(frame_tick), 32'd0);
        i_vs = 1'b0; i_hs = 1'b0; i_de = 1'b0; i_data = '0; x = '0; y = '0;
        @(negedge clk);
        probe("rel_box_br", 16, 16, 1'b1, 24'h0F0F0F, 24'hFF0000);
        probe("rel_box_out", 17, 16, 1'b1, 24'h0F0F0F, 24'h0F0F0F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
